// File: rtl/adf4030_bsync_align_ctrl_if.sv
// Register-map / BSYNC-generator side signals of the ADF4030 BSYNC alignment sequencer.
// master: the environment that drives requests and generator status; slave: the sequencer.
interface adf4030_bsync_align_ctrl_if;
  logic       start;
  logic       abort;
  logic       mode;
  logic       bsync_ready;
  logic       bsync_captured;
  logic       bsync_alignment_error;
  logic       direction;
  logic       disable_internal_bsync;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  modport master (
    output start, abort, mode, bsync_ready, bsync_captured, bsync_alignment_error,
    input  direction, disable_internal_bsync, busy, locked, fail, retry_cnt, state
  );

  modport slave (
    input  start, abort, mode, bsync_ready, bsync_captured, bsync_alignment_error,
    output direction, disable_internal_bsync, busy, locked, fail, retry_cnt, state
  );
endinterface

// File: rtl/adf4030_bsync_align_ctrl.sv
// ADF4030 BSYNC bring-up sequencer: settle, capture, verify, optional handover to internal drive.
// Optional macro ADF4030_AUTO_REALIGN_EN: alignment error in LOCKED re-enters SETTLE instead of FAIL.
module adf4030_bsync_align_ctrl #(
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned CAPTURE_TIMEOUT = 65535,
  parameter int unsigned VERIFY_PERIODS  = 4
) (
  input logic                       clk,
  input logic                       rstn,
  adf4030_bsync_align_ctrl_if.slave ctrl_bus
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CAP_W = $clog2(CAPTURE_TIMEOUT + 1);
  localparam int unsigned VER_W = $clog2(VERIFY_PERIODS + 1);
  localparam int unsigned RTY_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_VERIFY  = 3'd3;
  localparam logic [2:0] S_DRIVE   = 3'd4;
  localparam logic [2:0] S_LOCKED  = 3'd5;
  localparam logic [2:0] S_FAIL    = 3'd6;

  logic [2:0]       r_state, w_state_nxt;
  logic             r_mode, w_mode_nxt;
  logic [RTY_W-1:0] r_retry, w_retry_nxt;
  logic [SET_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
  logic [CAP_W-1:0] r_cap_cnt, w_cap_cnt_nxt;
  logic [VER_W-1:0] r_ver_cnt, w_ver_cnt_nxt;
  logic             r_drive_armed, w_drive_armed_nxt;
  logic             w_attempt_fail;
  logic             w_drive_nxt;
  logic             w_start_ok;

  logic r_direction, r_dis_int, r_busy, r_locked, r_fail;

  assign w_start_ok = ctrl_bus.start &&
                      ((r_state == S_IDLE) || (r_state == S_LOCKED) || (r_state == S_FAIL));

  // Next-state, counter and registered-output decode
  always_comb begin
    w_state_nxt       = r_state;
    w_mode_nxt        = r_mode;
    w_retry_nxt       = r_retry;
    w_settle_cnt_nxt  = r_settle_cnt;
    w_cap_cnt_nxt     = r_cap_cnt;
    w_ver_cnt_nxt     = r_ver_cnt;
    w_drive_armed_nxt = r_drive_armed;
    w_attempt_fail    = 1'b0;
    w_drive_nxt       = 1'b0;

    case (r_state)
      S_IDLE: ;
      S_SETTLE: begin
        if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_CAPTURE;
        else w_settle_cnt_nxt = r_settle_cnt + SET_W'(1);
      end
      S_CAPTURE: begin
        if (ctrl_bus.bsync_captured) w_state_nxt = S_VERIFY;
        else if (r_cap_cnt == CAP_W'(CAPTURE_TIMEOUT - 1)) w_attempt_fail = 1'b1;
        else w_cap_cnt_nxt = r_cap_cnt + CAP_W'(1);
      end
      S_VERIFY: begin
        // An error wins over a coincident ready pulse
        if (ctrl_bus.bsync_alignment_error) w_attempt_fail = 1'b1;
        else if (ctrl_bus.bsync_ready) begin
          if (r_ver_cnt == VER_W'(VERIFY_PERIODS - 1)) w_state_nxt = r_mode ? S_DRIVE : S_LOCKED;
          else w_ver_cnt_nxt = r_ver_cnt + VER_W'(1);
        end
      end
      S_DRIVE: begin
        // Ignore a ready pulse during the first DRIVE cycle
        if (!r_drive_armed) w_drive_armed_nxt = 1'b1;
        else if (ctrl_bus.bsync_ready) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (ctrl_bus.bsync_alignment_error) begin
`ifdef ADF4030_AUTO_REALIGN_EN
          w_state_nxt = S_SETTLE;
          w_retry_nxt = '0;
`else
          w_state_nxt = S_FAIL;
          w_retry_nxt = RTY_W'(MAX_RETRIES);
`endif
        end
      end
      S_FAIL: ;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_attempt_fail) begin
      if (r_retry < RTY_W'(MAX_RETRIES)) begin
        w_retry_nxt = r_retry + RTY_W'(1);
        w_state_nxt = S_SETTLE;
      end else begin
        w_state_nxt = S_FAIL;
      end
    end

    if (w_start_ok) begin
      w_state_nxt = S_SETTLE;
      w_mode_nxt  = ctrl_bus.mode;
      w_retry_nxt = '0;
    end

    if (ctrl_bus.abort) begin
      w_state_nxt = S_IDLE;
      w_mode_nxt  = r_mode;
      w_retry_nxt = r_retry;
    end

    if (w_state_nxt != r_state) begin
      w_settle_cnt_nxt  = '0;
      w_cap_cnt_nxt     = '0;
      w_ver_cnt_nxt     = '0;
      w_drive_armed_nxt = 1'b0;
    end

    w_drive_nxt = (w_state_nxt == S_DRIVE) || ((w_state_nxt == S_LOCKED) && w_mode_nxt);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_retry       <= '0;
      r_settle_cnt  <= '0;
      r_cap_cnt     <= '0;
      r_ver_cnt     <= '0;
      r_drive_armed <= 1'b0;
      r_direction   <= 1'b1;
      r_dis_int     <= 1'b1;
      r_busy        <= 1'b0;
      r_locked      <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_retry       <= w_retry_nxt;
      r_settle_cnt  <= w_settle_cnt_nxt;
      r_cap_cnt     <= w_cap_cnt_nxt;
      r_ver_cnt     <= w_ver_cnt_nxt;
      r_drive_armed <= w_drive_armed_nxt;
      r_direction   <= !w_drive_nxt;
      r_dis_int     <= !w_drive_nxt;
      r_busy        <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CAPTURE) ||
                       (w_state_nxt == S_VERIFY) || (w_state_nxt == S_DRIVE);
      r_locked      <= (w_state_nxt == S_LOCKED);
      r_fail        <= (w_state_nxt == S_FAIL);
    end
  end

  assign ctrl_bus.state                  = r_state;
  assign ctrl_bus.retry_cnt              = r_retry;
  assign ctrl_bus.direction              = r_direction;
  assign ctrl_bus.disable_internal_bsync = r_dis_int;
  assign ctrl_bus.busy                   = r_busy;
  assign ctrl_bus.locked                 = r_locked;
  assign ctrl_bus.fail                   = r_fail;

endmodule

// File: tb/tb_adf4030_bsync_align_ctrl.sv
// Bench for adf4030_bsync_align_ctrl: directed test-plan steps then random traffic against a
// behavioural model that tracks time-in-state and pulse counts with plain integers.
module tb_adf4030_bsync_align_ctrl;
  localparam int MAX_RETRIES     = 3;
  localparam int SETTLE_CYCLES   = 4;
  localparam int CAPTURE_TIMEOUT = 100;
  localparam int VERIFY_PERIODS  = 4;

  logic clk;
  logic rstn;
  int   vectors     = 0;
  int   miscompares = 0;

  int m_state, m_retry, m_age, m_pulses;
  bit m_mode;

  adf4030_bsync_align_ctrl_if bus();

  adf4030_bsync_align_ctrl #(
    .MAX_RETRIES    (MAX_RETRIES),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .CAPTURE_TIMEOUT(CAPTURE_TIMEOUT),
    .VERIFY_PERIODS (VERIFY_PERIODS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ctrl_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic go(input int s);
    m_state  = s;
    m_age    = 0;
    m_pulses = 0;
  endtask

  task automatic model_reset();
    m_retry = 0;
    m_mode  = 1'b0;
    go(0);
  endtask

  task automatic attempt_failed();
    if (m_retry < MAX_RETRIES) begin
      m_retry++;
      go(1);
    end else begin
      go(6);
    end
  endtask

  // States numbered as read back on the state port: 0 idle .. 6 fail
  task automatic model_step(input bit st, input bit ab, input bit md,
                            input bit rd, input bit cp, input bit er);
    if (ab) begin
      go(0);
      return;
    end
    if (st && (m_state == 0 || m_state == 5 || m_state == 6)) begin
      m_mode  = md;
      m_retry = 0;
      go(1);
      return;
    end
    m_age++;
    case (m_state)
      1: if (m_age == SETTLE_CYCLES) go(2);
      2: begin
        if (cp) go(3);
        else if (m_age == CAPTURE_TIMEOUT) attempt_failed();
      end
      3: begin
        if (er) attempt_failed();
        else if (rd) begin
          m_pulses++;
          if (m_pulses == VERIFY_PERIODS) go(m_mode ? 4 : 5);
        end
      end
      4: if (rd && m_age > 1) go(5);
      5: begin
        if (er) begin
`ifdef ADF4030_AUTO_REALIGN_EN
          m_retry = 0;
          go(1);
`else
          m_retry = MAX_RETRIES;
          go(6);
`endif
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [11:0] obs, exp;
    bit drv;
    drv = (m_state == 4) || (m_state == 5 && m_mode);
    obs = {bus.state, bus.retry_cnt, bus.direction, bus.disable_internal_bsync,
           bus.busy, bus.locked, bus.fail};
    exp = {3'(m_state), 4'(m_retry), !drv, !drv,
           (m_state >= 1 && m_state <= 4), (m_state == 5), (m_state == 6)};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed state=%0d retry=%0d dir,dis,busy,locked,fail=%b expected state=%0d retry=%0d dir,dis,busy,locked,fail=%b",
             tag, obs[11:9], obs[8:5], obs[4:0], exp[11:9], exp[8:5], exp[4:0]);
    end
  endtask

  task automatic expect_val(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit st, input bit ab, input bit md,
                     input bit rd, input bit cp, input bit er);
    bus.start                 = st;
    bus.abort                 = ab;
    bus.mode                  = md;
    bus.bsync_ready           = rd;
    bus.bsync_captured        = cp;
    bus.bsync_alignment_error = er;
    @(posedge clk);
    model_step(st, ab, md, rd, cp, er);
    #1;
    check_all("cycle");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic to_verify_pulses(input int n);
    idle(SETTLE_CYCLES);
    idle(4);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < n; i++) begin
      idle(1);
      cyc(0, 0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.bsync_ready = 1'b0; bus.bsync_captured = 1'b0; bus.bsync_alignment_error = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    expect_val("reset_state", int'(bus.state), 0);
    expect_val("reset_direction", int'(bus.direction), 1);
    rstn = 1'b1;

    // Receive-only lock
    cyc(1, 0, 0, 0, 0, 0);
    expect_val("start_busy", int'(bus.busy), 1);
    idle(SETTLE_CYCLES);
    expect_val("capture_entry", int'(bus.state), 2);
    idle(4);
    cyc(0, 0, 0, 0, 1, 0);
    expect_val("verify_entry", int'(bus.state), 3);
    for (int i = 0; i < VERIFY_PERIODS; i++) begin
      idle(1);
      cyc(0, 0, 0, 1, 0, 0);
    end
    expect_val("rx_locked", int'(bus.locked), 1);
    expect_val("rx_direction", int'(bus.direction), 1);
    expect_val("rx_retry", int'(bus.retry_cnt), 0);
    expect_val("rx_state", int'(bus.state), 5);
    idle(2);

    // Drive lock, restarted from LOCKED
    cyc(1, 0, 1, 0, 0, 0);
    to_verify_pulses(VERIFY_PERIODS);
    expect_val("drive_state", int'(bus.state), 4);
    expect_val("drive_direction", int'(bus.direction), 0);
    expect_val("drive_disable", int'(bus.disable_internal_bsync), 0);
    cyc(0, 0, 0, 1, 0, 0);
    expect_val("drive_entry_pulse_ignored", int'(bus.state), 4);
    idle(2);
    cyc(0, 0, 0, 1, 0, 0);
    expect_val("drive_locked", int'(bus.state), 5);
    expect_val("drive_locked_dir", int'(bus.direction), 0);

    // Abort mid-DRIVE with a coincident start
    cyc(1, 0, 1, 0, 0, 0);
    to_verify_pulses(VERIFY_PERIODS);
    idle(1);
    cyc(1, 1, 0, 0, 0, 0);
    expect_val("abort_state", int'(bus.state), 0);
    expect_val("abort_direction", int'(bus.direction), 1);
    expect_val("abort_disable", int'(bus.disable_internal_bsync), 1);

    // Alignment error on 2nd verify pulse, then a clean attempt
    cyc(1, 0, 0, 0, 0, 0);
    to_verify_pulses(1);
    idle(1);
    cyc(0, 0, 0, 1, 0, 1);
    expect_val("err_retry_state", int'(bus.state), 1);
    expect_val("err_retry_cnt", int'(bus.retry_cnt), 1);
    to_verify_pulses(VERIFY_PERIODS);
    expect_val("err_then_locked", int'(bus.locked), 1);
    expect_val("err_then_retry", int'(bus.retry_cnt), 1);

    // Alignment error while LOCKED
    cyc(0, 0, 0, 0, 0, 1);
`ifdef ADF4030_AUTO_REALIGN_EN
    expect_val("locked_err_state", int'(bus.state), 1);
    expect_val("locked_err_retry", int'(bus.retry_cnt), 0);
`else
    expect_val("locked_err_state", int'(bus.state), 6);
    expect_val("locked_err_retry", int'(bus.retry_cnt), MAX_RETRIES);
`endif
    cyc(0, 1, 0, 0, 0, 0);

    // Capture timeout on every attempt
    cyc(1, 0, 0, 0, 0, 0);
    for (int r = 1; r <= MAX_RETRIES; r++) begin
      idle(SETTLE_CYCLES + CAPTURE_TIMEOUT);
      expect_val("timeout_retry", int'(bus.retry_cnt), r);
    end
    idle(SETTLE_CYCLES + CAPTURE_TIMEOUT);
    expect_val("timeout_fail", int'(bus.fail), 1);
    expect_val("timeout_state", int'(bus.state), 6);
    expect_val("timeout_busy", int'(bus.busy), 0);
    cyc(1, 0, 1, 0, 0, 0);
    expect_val("restart_from_fail", int'(bus.state), 1);

    // Reset mid-sequence always returns to IDLE
    idle(3);
    rstn = 1'b0;
    #2;
    model_reset();
    check_all("async_reset");
    rstn = 1'b1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit st, ab, md, rd, cp, er;
      st = ($urandom_range(0, 99) < 4);
      ab = ($urandom_range(0, 199) == 0);
      md = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) == 0);
      cp = ($urandom_range(0, 19) == 0);
      er = ($urandom_range(0, 29) == 0);
      cyc(st, ab, md, rd, cp, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
